// File: rtl/fizzbuzz_sequencer_if.sv
// rtl/fizzbuzz_sequencer_if.sv - result stream bundle between the sequencer and its consumer
interface fizzbuzz_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_num;
    logic             out_fizz;
    logic             out_buzz;

    modport master (
        output out_valid,
        output out_num,
        output out_fizz,
        output out_buzz,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_num,
        input  out_fizz,
        input  out_buzz,
        output out_ready
    );
endinterface

// File: rtl/fizzbuzz_sequencer.sv
// rtl/fizzbuzz_sequencer.sv - walks first..last and streams mod-3 / mod-5 divisibility flags without a divider
module fizzbuzz_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [WIDTH-1:0]      first,
    input  logic [WIDTH-1:0]      last,
    output logic                  busy,
    output logic                  done,
    fizzbuzz_sequencer_if.master  bus
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] first_q, first_nxt;
    logic [WIDTH-1:0] last_q, last_nxt;
    logic [1:0]       r3, r3_nxt;
    logic [2:0]       r5, r5_nxt;
    logic [IW-1:0]    idx, idx_nxt;
    logic             busy_nxt, done_nxt;
    logic             valid_nxt, fizz_nxt, buzz_nxt;
    logic [WIDTH-1:0] num_nxt;

    logic             bit_in;
    logic [2:0]       dbl3, dbl5;
    logic [1:0]       r3_dbl, r3_inc;
    logic [2:0]       r5_dbl, r5_inc;

    // Residue steps: shift-in of one MSB-first bit, and +1 for the running value.
    // dbl5 may wrap modulo 8 when r5 >= 3, but the true residue is 1..4 so subtracting 5 mod 8 lands correctly.
    always_comb begin
        bit_in = first_q[idx];
        dbl3   = {r3, 1'b0} + {2'b00, bit_in};
        r3_dbl = (dbl3 >= 3'd3) ? 2'(dbl3 - 3'd3) : dbl3[1:0];
        dbl5   = {r5[1:0], 1'b0} + {2'b00, bit_in};
        r5_dbl = ((r5 >= 3'd3) || (dbl5 >= 3'd5)) ? (dbl5 - 3'd5) : dbl5;
        r3_inc = (r3 == 2'd2) ? 2'd0 : (r3 + 2'd1);
        r5_inc = (r5 == 3'd4) ? 3'd0 : (r5 + 3'd1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            first_q       <= '0;
            last_q        <= '0;
            r3            <= '0;
            r5            <= '0;
            idx           <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_num   <= '0;
            bus.out_fizz  <= 1'b0;
            bus.out_buzz  <= 1'b0;
        end else begin
            state         <= state_nxt;
            first_q       <= first_nxt;
            last_q        <= last_nxt;
            r3            <= r3_nxt;
            r5            <= r5_nxt;
            idx           <= idx_nxt;
            busy          <= busy_nxt;
            done          <= done_nxt;
            bus.out_valid <= valid_nxt;
            bus.out_num   <= num_nxt;
            bus.out_fizz  <= fizz_nxt;
            bus.out_buzz  <= buzz_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        first_nxt = first_q;
        last_nxt  = last_q;
        r3_nxt    = r3;
        r5_nxt    = r5;
        idx_nxt   = idx;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        valid_nxt = bus.out_valid;
        num_nxt   = bus.out_num;
        fizz_nxt  = bus.out_fizz;
        buzz_nxt  = bus.out_buzz;

        case (state)
            IDLE: begin
                if (start) begin
                    if (first <= last) begin
                        first_nxt = first;
                        last_nxt  = last;
                        r3_nxt    = '0;
                        r5_nxt    = '0;
                        idx_nxt   = IW'(WIDTH - 1);
                        busy_nxt  = 1'b1;
                        state_nxt = INIT;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end

            INIT: begin
                if (abort) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                end else begin
                    r3_nxt  = r3_dbl;
                    r5_nxt  = r5_dbl;
                    idx_nxt = idx - IW'(1);
                    if (idx == '0) begin
                        state_nxt = RUN;
                        valid_nxt = 1'b1;
                        num_nxt   = first_q;
                        fizz_nxt  = (r3_dbl == 2'd0);
                        buzz_nxt  = (r5_dbl == 3'd0);
                    end
                end
            end

            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                    valid_nxt = 1'b0;
                    busy_nxt  = 1'b0;
                end else if (bus.out_ready) begin
                    // Stop on last before incrementing so last = all-ones never wraps.
                    if (bus.out_num == last_q) begin
                        state_nxt = IDLE;
                        valid_nxt = 1'b0;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end else begin
                        num_nxt  = bus.out_num + WIDTH'(1);
                        r3_nxt   = r3_inc;
                        r5_nxt   = r5_inc;
                        fizz_nxt = (r3_inc == 2'd0);
                        buzz_nxt = (r5_inc == 3'd0);
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
                valid_nxt = 1'b0;
                busy_nxt  = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_fizzbuzz_sequencer.sv
// tb/tb_fizzbuzz_sequencer.sv - directed self-checking bench for fizzbuzz_sequencer
module tb_fizzbuzz_sequencer;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] first = '0;
    logic [W-1:0] last = '0;
    logic         busy;
    logic         done;

    int tests = 0;
    int fails = 0;

    fizzbuzz_sequencer_if #(.WIDTH(W)) bus ();

    fizzbuzz_sequencer #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .abort (abort),
        .first (first),
        .last  (last),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_valid"}, bus.out_valid, 0);
        check({tag, "_done"},  done, 0);
        check({tag, "_num"},   bus.out_num, 0);
        check({tag, "_fizz"},  bus.out_fizz, 0);
        check({tag, "_buzz"},  bus.out_buzz, 0);
    endtask

    task automatic issue_start(input int f, input int l);
        @(negedge clk);
        first = W'(f);
        last  = W'(l);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_num(input string tag, input int n);
        int g;
        g = 0;
        while (!(bus.out_valid && bus.out_num == W'(n)) && g < 100) begin
            @(negedge clk);
            g++;
        end
        check(tag, bus.out_num, n);
    endtask

    task automatic run_range(input int f, input int l, input bit rnd,
                             output int nbeats, output int nfizz, output int nbuzz, output int nboth);
        int  lat;
        int  expn;
        int  guard;
        bit  acc;
        bit  fin;
        nbeats = 0; nfizz = 0; nbuzz = 0; nboth = 0;
        bus.out_ready = 1'b1;
        issue_start(f, l);
        if (f > l) begin
            check("empty_done", done, 1);
            check("empty_busy", busy, 0);
            check("empty_valid", bus.out_valid, 0);
            @(negedge clk);
            check("empty_done_once", done, 0);
            check("empty_busy2", busy, 0);
            return;
        end
        check("init_busy", busy, 1);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            lat++;
            @(negedge clk);
        end
        check("latency", lat, W);
        expn  = f;
        fin   = 1'b0;
        guard = 0;
        while (!fin && guard < 500) begin
            guard++;
            check("valid", bus.out_valid, 1);
            if (!bus.out_valid) break;
            check("num",  bus.out_num, expn);
            check("fizz", bus.out_fizz, (expn % 3) == 0);
            check("buzz", bus.out_buzz, (expn % 5) == 0);
            bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            acc = bus.out_ready;
            if (acc) begin
                nbeats++;
                if (bus.out_fizz) nfizz++;
                if (bus.out_buzz) nbuzz++;
                if (bus.out_fizz && bus.out_buzz) nboth++;
            end
            @(posedge clk);
            @(negedge clk);
            if (acc) begin
                if (expn == l) begin
                    check("end_valid", bus.out_valid, 0);
                    check("end_done", done, 1);
                    check("end_busy", busy, 0);
                    @(negedge clk);
                    check("done_once", done, 0);
                    fin = 1'b1;
                end else begin
                    expn++;
                end
            end
        end
        check("run_finished", fin, 1);
        bus.out_ready = 1'b1;
    endtask

    initial begin
        int nb, nf, nz, nfb;
        bus.out_ready = 1'b0;
        #1 rst = 1'b1;
        #1 check_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_range(1, 15, 1'b0, nb, nf, nz, nfb);
        check("r1_beats", nb, 15);
        check("r1_fizz",  nf, 5);
        check("r1_buzz",  nz, 3);
        check("r1_both",  nfb, 1);

        run_range(250, 255, 1'b1, nb, nf, nz, nfb);
        check("r2_beats", nb, 6);
        check("r2_fizz",  nf, 2);
        check("r2_buzz",  nz, 2);
        check("r2_both",  nfb, 1);

        run_range(0, 0, 1'b0, nb, nf, nz, nfb);
        check("r3_beats", nb, 1);
        check("r3_both",  nfb, 1);

        run_range(9, 3, 1'b0, nb, nf, nz, nfb);
        check("r4_beats", nb, 0);

        // Hold at 6, then abort together with ready.
        bus.out_ready = 1'b1;
        issue_start(1, 15);
        wait_num("abort_at6", 6);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("hold_valid", bus.out_valid, 1);
            check("hold_num",   bus.out_num, 6);
            check("hold_fizz",  bus.out_fizz, 1);
            check("hold_buzz",  bus.out_buzz, 0);
        end
        bus.out_ready = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_valid", bus.out_valid, 0);
        check("abort_done",  done, 0);
        check("abort_busy",  busy, 0);
        @(negedge clk);
        check("abort_no_done", done, 0);
        run_range(30, 30, 1'b0, nb, nf, nz, nfb);
        check("r5_beats", nb, 1);
        check("r5_both",  nfb, 1);

        // Reset during INIT.
        issue_start(1, 15);
        repeat (3) @(negedge clk);
        check("init_busy_pre_rst", busy, 1);
        rst = 1'b1;
        #1 check_zero("rst_init");
        @(negedge clk);
        rst = 1'b0;

        // start while busy is ignored, then reset mid-run at 7.
        issue_start(1, 15);
        wait_num("busy_at5", 5);
        first = W'(200);
        last  = W'(210);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ignore_start6", bus.out_num, 6);
        @(negedge clk);
        check("ignore_start7", bus.out_num, 7);
        rst = 1'b1;
        #1 check_zero("rst_run");
        @(negedge clk);
        rst = 1'b0;

        run_range(10, 12, 1'b0, nb, nf, nz, nfb);
        check("r6_beats", nb, 3);
        check("r6_fizz",  nf, 1);
        check("r6_buzz",  nz, 1);
        check("r6_both",  nfb, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
